// File: rtl/fft_out_serializer.sv
// fft_out_serializer
// Turns whole 16-point FFT frames (delivered in one cycle by the fft_16_4
// output stage) into a stream of complex samples with valid/ready handshake.
// Two frame buffers form a ping-pong FIFO, so a new frame can be captured
// while the previous one drains. If a frame arrives while both buffers are
// full, it is dropped. Dropped frames are counted.
//
// Build option: define FFT_SER_BITREV_EN to emit the bins in bit-reversed
// order. In that mode o_index carries the bit-reversed bin number. Without
// it, bins come out in natural order.
//
// Ports
//   clk        rising-edge clock
//   rst_sync   synchronous active-high reset
//   i_valid    one-cycle pulse: full frame present on i_data
//   i_data     [16][2] x OUTPUT_WIDTH frame, [k][0] real, [k][1] imag
//   o_valid    sample on o_data valid
//   o_ready    downstream accepts (transfer = o_valid && o_ready)
//   o_data     [2] x OUTPUT_WIDTH sample, [0] real, [1] imag
//   o_index    bin index of the sample on o_data
//   o_last     marks the 16th sample of a frame
//   overflow   one-cycle pulse when a frame is dropped
//   ovf_count  saturating count of dropped frames
module fft_out_serializer #(
  parameter int OUTPUT_WIDTH  = 16,
  parameter int OVF_CNT_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_sync,
  input  logic                               i_valid,
  input  logic [15:0][1:0][OUTPUT_WIDTH-1:0] i_data,
  output logic                               o_valid,
  input  logic                               o_ready,
  output logic [1:0][OUTPUT_WIDTH-1:0]       o_data,
  output logic [3:0]                         o_index,
  output logic                               o_last,
  output logic                               overflow,
  output logic [OVF_CNT_WIDTH-1:0]           ovf_count
);

  typedef logic [15:0][1:0][OUTPUT_WIDTH-1:0] frame_t;
  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t     state;
  state_t     state_nxt;
  frame_t     buf_mem [2];
  frame_t     src_frame;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       rd_ptr_nxt;
  logic [1:0] fill;
  logic [1:0] fill_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [3:0] bin_nxt;
  logic       xfer;
  logic       last_xfer;
  logic       accept;
  logic       drop;

  function automatic logic [3:0] bitrev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  // Next-state computation: handshake, buffer bookkeeping and the sample to present next cycle
  always_comb begin
    xfer       = o_valid && o_ready;
    last_xfer  = xfer && (cnt == 4'd15);
    // A 16th transfer frees a buffer in the same edge, so a full block can still accept.
    accept     = i_valid && ((fill != 2'd2) || last_xfer);
    drop       = i_valid && !accept;
    fill_nxt   = fill - {1'b0, last_xfer} + {1'b0, accept};
    rd_ptr_nxt = rd_ptr ^ last_xfer;
    cnt_nxt    = cnt + {3'b000, xfer};
    // The frame being captured right now is the one to read next only when the
    // read side would otherwise be empty; forward it so sample 0 appears at N+1.
    if (accept && (wr_ptr == rd_ptr_nxt)) begin
      src_frame = i_data;
    end else begin
      src_frame = buf_mem[rd_ptr_nxt];
    end
    if (fill_nxt != 2'd0) begin
      state_nxt = STREAM;
    end else begin
      state_nxt = IDLE;
    end
`ifdef FFT_SER_BITREV_EN
    bin_nxt = bitrev4(cnt_nxt);
`else
    bin_nxt = cnt_nxt;
`endif
  end

  // State, buffers, pointers and registered outputs
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state     <= IDLE;
      fill      <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      cnt       <= 4'd0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_index   <= 4'd0;
      o_last    <= 1'b0;
      overflow  <= 1'b0;
      ovf_count <= '0;
    end else begin
      if (accept) begin
        buf_mem[wr_ptr] <= i_data;
      end
      state    <= state_nxt;
      fill     <= fill_nxt;
      wr_ptr   <= wr_ptr ^ accept;
      rd_ptr   <= rd_ptr_nxt;
      cnt      <= cnt_nxt;
      overflow <= drop;
      if (drop && (ovf_count != {OVF_CNT_WIDTH{1'b1}})) begin
        ovf_count <= ovf_count + {{(OVF_CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      case (state_nxt)
        STREAM: begin
          o_valid <= 1'b1;
          o_data  <= src_frame[bin_nxt];
          o_index <= bin_nxt;
          o_last  <= (cnt_nxt == 4'd15);
        end
        default: begin
          o_valid <= 1'b0;
          o_data  <= '0;
          o_index <= bin_nxt;
          o_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
